// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - parity check receiver with 2-entry elastic buffer; optional PARITY_ERR_CNT_EN error counter
module parity_checker #(
  parameter int DATA_W  = 8,
  parameter bit ODD_PAR = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              err_flag,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] head_data;
  logic              head_err;
  logic [DATA_W-1:0] tail_data;
  logic              tail_err;
  logic              in_ready_q;
  logic              out_valid_q;

  logic push;
  logic pop;
  logic mism;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;
  // Mismatch is tagged at the input so the stored word carries its own verdict
  assign mism = in_parity ^ (^in_data) ^ ODD_PAR;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data;
  assign out_err   = head_err;

  // Buffer FSM: head is always the presented word, tail only holds the second entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      head_data   <= '0;
      head_err    <= 1'b0;
      tail_data   <= '0;
      tail_err    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            head_data   <= in_data;
            head_err    <= mism;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_data <= in_data;
            head_err  <= mism;
          end else if (push) begin
            tail_data  <= in_data;
            tail_err   <= mism;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_data  <= tail_data;
            head_err   <= tail_err;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag: a mismatching push wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
    end else if (push && mism) begin
      err_flag <= 1'b1;
    end else if (clr_err) begin
      err_flag <= 1'b0;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating mismatch counter; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_err) begin
      cnt_q <= '0;
    end else if (push && mism && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_checker.sv
// tb/tb_parity_checker.sv - directed self-checking bench for parity_checker
module tb_parity_checker;

  logic       clk;
  logic       reset_n;
  logic       clr_err;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_parity;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       err_flag;
  logic [1:0] err_cnt;

  logic       o_in_valid;
  logic       o_in_ready;
  logic [7:0] o_in_data;
  logic       o_in_parity;
  logic       o_out_valid;
  logic       o_out_ready;
  logic [7:0] o_out_data;
  logic       o_out_err;
  logic       o_err_flag;
  logic [1:0] o_err_cnt;

  int tests;
  int fails;

  parity_checker #(.DATA_W(8), .ODD_PAR(1'b0), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_flag(err_flag), .clr_err(clr_err), .err_cnt(err_cnt)
  );

  parity_checker #(.DATA_W(8), .ODD_PAR(1'b1), .CNT_W(2)) dut_odd (
    .clk(clk), .reset_n(reset_n),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_parity(o_in_parity),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data), .out_err(o_out_err),
    .err_flag(o_err_flag), .clr_err(clr_err), .err_cnt(o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clr_err = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_parity = 1'b0; out_ready = 1'b1;
    o_in_valid = 1'b0; o_in_data = 8'h00; o_in_parity = 1'b0; o_out_ready = 1'b1;
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL rst_out_err: got %b expected 0", out_err); end
    tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL rst_err_flag: got %b expected 0", err_flag); end
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
    reset_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_good_word();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5; in_parity = 1'b0;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL good_out_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL good_out_data: got %h expected a5", out_data); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL good_out_err: got %b expected 0", out_err); end
    tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL good_err_flag: got %b expected 0", err_flag); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL good_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_bad_word();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01; in_parity = 1'b0;
    step();
    in_valid = 1'b0;
    tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL bad_out_err: got %b expected 1", out_err); end
    tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL bad_err_flag: got %b expected 1", err_flag); end
    step(); step();
    tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL bad_sticky: got %b expected 1", err_flag); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL bad_clear: got %b expected 0", err_flag); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; in_parity = 1'b0;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_one: got %b expected 1", in_ready); end
    in_data = 8'h22;
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_two: got %b expected 0", in_ready); end
    tests++; if (out_data !== 8'h11) begin fails++; $display("FAIL b2b_head0: got %h expected 11", out_data); end
    in_data = 8'h33;
    step();
    tests++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_hold: got %h/%b expected 11/1", out_data, out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_hold: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    step();
    tests++; if (out_data !== 8'h22) begin fails++; $display("FAIL b2b_word1: got %h expected 22", out_data); end
    step();
    in_valid = 1'b0;
    tests++; if (out_data !== 8'h33 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_word2: got %h/%b expected 33/1", out_data, out_valid); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_odd_parity();
    o_out_ready = 1'b1;
    o_in_valid = 1'b1; o_in_data = 8'h00; o_in_parity = 1'b1;
    step();
    tests++; if (o_out_err !== 1'b0 || o_out_valid !== 1'b1) begin fails++; $display("FAIL odd_good: got err=%b valid=%b expected 0/1", o_out_err, o_out_valid); end
    o_in_parity = 1'b0;
    step();
    o_in_valid = 1'b0;
    tests++; if (o_out_err !== 1'b1) begin fails++; $display("FAIL odd_bad: got %b expected 1", o_out_err); end
    tests++; if (o_err_flag !== 1'b1) begin fails++; $display("FAIL odd_flag: got %b expected 1", o_err_flag); end
    step();
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; in_parity = 1'b0;
    step();
`ifdef PARITY_ERR_CNT_EN
    tests++; if (err_cnt !== 2'd1) begin fails++; $display("FAIL cnt_one: got %0d expected 1", err_cnt); end
`else
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL cnt_tied: got %0d expected 0", err_cnt); end
`endif
    step(); step(); step(); step();
`ifdef PARITY_ERR_CNT_EN
    tests++; if (err_cnt !== 2'd3) begin fails++; $display("FAIL cnt_sat: got %0d expected 3", err_cnt); end
`else
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL cnt_tied5: got %0d expected 0", err_cnt); end
`endif
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    in_valid = 1'b0;
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL cnt_clear: got %0d expected 0", err_cnt); end
    tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL clr_vs_set: got %b expected 1", err_flag); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; in_parity = 1'b0;
    step();
    in_data = 8'h07; in_parity = 1'b0;
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0 || err_flag !== 1'b1) begin fails++; $display("FAIL mid_full: got ready=%b flag=%b expected 0/1", in_ready, err_flag); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL mid_err_flag: got %b expected 0", err_flag); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready_low: got %b expected 0", in_ready); end
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_good_word();
    test_bad_word();
    test_back_to_back();
    test_odd_parity();
    test_counter();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
